// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings, handshake levels and execute-stage aluop codes for the divider
package div_unit_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic [7:0] DIV_OP  = 8'b00011010;
  localparam logic [7:0] DIVU_OP = 8'b00011011;
endpackage

// File: rtl/div_unit_if.sv
// div_if: execute-stage <-> divider request/result handshake
interface div_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
  modport slave  (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/div_unit_step.sv
// div_step: one radix-2 restoring iteration on {rem, quo}; the bit shifted out of rem joins the trial subtract
module div_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] next
);
  logic [WIDTH:0] hi;
  logic [WIDTH:0] trial;
  // shift, trial-subtract, restore on borrow
  always_comb begin
    hi    = acc[2*WIDTH-1:WIDTH-1];
    trial = hi - {1'b0, divisor};
    next  = trial[WIDTH] ? {hi[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                         : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU divider, one quotient bit per cycle; DIV_EARLY_TERM_EN skips |a|<|b| divides
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  div_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   divisor;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  // signed divides work on magnitudes; signs are restored on entry to DivEnd
  always_comb begin
    a_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    b_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    q_mag = step[WIDTH-1:0];
    r_mag = step[2*WIDTH-1:WIDTH];
  end
  div_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .divisor (divisor),
    .next    (step)
  );
  // control FSM with registered result/ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= '0;
      acc          <= '0;
      divisor      <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: if (bus.start_i == DivStart && !bus.annul_i) begin
          acc     <= {{WIDTH{1'b0}}, a_mag};
          divisor <= b_mag;
          neg_q   <= bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          neg_r   <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
          cnt     <= '0;
          if (bus.opdata2_i == '0) state <= DivByZero;
`ifdef DIV_EARLY_TERM_EN
          else if (a_mag < b_mag) begin
            state        <= DivEnd;
            bus.result_o <= {bus.opdata1_i, {WIDTH{1'b0}}};
            bus.ready_o  <= DivResultReady;
          end
`endif
          else state <= DivOn;
        end
        DivByZero: begin
          state        <= DivEnd;
          bus.result_o <= '0;
          bus.ready_o  <= DivResultReady;
        end
        DivOn: if (bus.annul_i) begin
          state       <= DivFree;
          cnt         <= '0;
          bus.ready_o <= DivResultNotReady;
        end else begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            state        <= DivEnd;
            bus.result_o <= {neg_r ? -r_mag : r_mag, neg_q ? -q_mag : q_mag};
            bus.ready_o  <= DivResultReady;
          end
        end
        DivEnd: if (bus.start_i == DivStop) begin
          state        <= DivFree;
          bus.result_o <= '0;
          bus.ready_o  <= DivResultNotReady;
        end
        default: state <= DivFree;
      endcase
    end
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU.
- Execute stage is the initiator: it raises a start request with operands and stalls the pipeline until this block reports ready.
- Block returns {remainder, quotient}; execute forwards remainder to HI and quotient to LO over its existing HI/LO write path.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by execute until ready_o is seen.
- annul_i  in  1  cancel the in-flight divide (branch-delay flush or exception).
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1.
- ready_o  out  1  result valid.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, ready_o = 0, result_o = 0, counter = 0, working registers = 0.
- States and transitions:
  - IDLE: on start_i=1 and annul_i=0, latch operands. Divisor == 0 -> BYZERO; otherwise -> ON with cnt = 0.
  - IDLE with signed_div_i=1: latch magnitudes. Negative dividend/divisor are negated before latching.
  - BYZERO: unconditionally -> END, result = 0.
  - ON: annul_i=1 -> IDLE with ready_o = 0 and no result. Otherwise perform one iteration per cycle.
  - Iteration: shift {rem, quo} left by 1; trial = rem_hi - divisor (WIDTH+1 bits). If non-negative, rem_hi = trial and quo LSB = 1; else quo LSB = 0. cnt++.
  - ON, after the iteration with cnt == WIDTH-1: -> END.
  - Sign fix-up on entry to END when signed: quotient negated if dividend and divisor signs differ; remainder negated if the dividend was negative.
  - END: ready_o = 1, result_o stable. Stays in END while start_i = 1. When start_i = 0 -> IDLE, ready_o = 0 and result_o = 0 on that edge.
- Latency, with start sampled at edge N:
  - Normal divide: ready_o high from cycle N+33 (32 iterations in cycles N+1..N+32, then END).
  - Divide by zero: ready_o high from cycle N+2.
- Boundary conditions:
  - start_i and annul_i both 1 in IDLE: annul wins, stay IDLE.
  - annul_i in END: ignored; release is by start_i only.
  - start_i dropped during ON (protocol violation): divide completes anyway, END -> IDLE next cycle.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 (wraps; no trap).
  - Operands are sampled only in IDLE; changes on operand inputs during ON are ignored.
  - rst at any state: IDLE next edge, outputs cleared.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined: in IDLE, if divisor != 0 and |dividend| < |divisor| (unsigned magnitude compare), go directly to END.
  - quotient = 0, remainder = original dividend (sign already correct), ready_o at N+1.
- Undefined: every nonzero-divisor divide takes the full 33-cycle path; results are identical either way.

Decomposition:
- Shared defines include:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2-bit);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - the DIV_OP/DIVU_OP aluop codes used by execute.
- One sub-module is natural: div_step. It is combinational: takes {rem, quo} and the divisor, and returns the shifted/subtracted {rem, quo}.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- Unsigned 100 / 7 -> result_o = {0x00000002, 0x0000000E}, ready_o rises exactly 33 cycles after start is sampled; drop start -> ready_o = 0 next cycle.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (signed and unsigned, dividend 0x12345678) -> result_o = 0, ready_o at N+2.
- Start 0xFFFFFFFF / 3 unsigned, assert annul_i at iteration 10 -> ready_o never rises, back in IDLE. Then start 9/3 -> {0, 3} at N+33.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Hold start_i 5 extra cycles in END -> result_o unchanged.
- rst pulsed mid-ON -> next cycle ready_o = 0, result_o = 0. With DIV_EARLY_TERM_EN defined, 3 / 10 unsigned -> {0x00000003, 0} at N+1.
